// File: rtl/kb_event_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// kb_event_ctrl_pkg
// Shared definitions for the keyboard event path between kb_driver and the
// CPU keyboard port:
//   - the layout of a 16-bit key event word
//   - the one-hot state encoding of the typematic scheduler
//   - a helper that packs an event word from its fields
// -----------------------------------------------------------------------------
package kb_event_ctrl_pkg;

   // Event word layout: [15] repeat flag, [14:13] zero, [12:8] mods, [7:0] ascii
   localparam int KB_EVT_W          = 16;
   localparam int KB_EVT_REPEAT_BIT = 15;
   localparam int KB_EVT_MODS_HI    = 12;
   localparam int KB_EVT_MODS_LO    = 8;
   localparam int KB_EVT_ASCII_HI   = 7;
   localparam int KB_EVT_ASCII_LO   = 0;

   // Typematic scheduler states, one-hot
   typedef enum logic [2:0] {
      KB_ST_IDLE   = 3'b001,
      KB_ST_DELAY  = 3'b010,
      KB_ST_REPEAT = 3'b100
   } kb_state_e;

   // Builds an event word; the two unused bits are always zero
   function automatic logic [KB_EVT_W-1:0] kb_evt_pack(
      input logic       rep,
      input logic [4:0] mods,
      input logic [7:0] ascii
   );
      logic [KB_EVT_W-1:0] evt;
      evt                                    = 16'h0000;
      evt[KB_EVT_REPEAT_BIT]                 = rep;
      evt[KB_EVT_MODS_HI:KB_EVT_MODS_LO]     = mods;
      evt[KB_EVT_ASCII_HI:KB_EVT_ASCII_LO]   = ascii;
      return evt;
   endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// -----------------------------------------------------------------------------
// kb_event_fifo
// Synchronous first-word-fall-through FIFO for key events.
//   clk, rst     : clock, synchronous active-high reset
//   push         : write push_data this cycle (dropped if full and no pop)
//   push_data    : event word to enqueue
//   pop          : remove head entry (ignored while empty)
//   ovf_clr      : clear the sticky overflow flag (a drop in the same cycle wins)
//   rd_data      : registered head entry; holds its last value while empty
//   empty        : registered, no entries queued
//   count        : registered number of queued entries, 0..2^DEPTH_LOG2
//   overflow     : sticky, set when a push was dropped
// A push together with a pop on a full FIFO is accepted (the pop frees the
// slot in the same cycle); a pop on an empty FIFO is ignored even when a
// push arrives in that cycle.
// -----------------------------------------------------------------------------
module kb_event_fifo
   import kb_event_ctrl_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3,
   parameter int WIDTH      = KB_EVT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   input  logic                  ovf_clr,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int PW    = DEPTH_LOG2;

   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ZERO = PW'(0);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             empty_q, empty_d;
   logic             overflow_q, overflow_d;

   logic             full_s;
   logic             is_empty_s;
   logic             pop_ok_s;
   logic             push_ok_s;
   logic             drop_s;

   // Accept/drop decisions from the current occupancy
   always_comb begin
      full_s     = (count_q == CNT_FULL);
      is_empty_s = (count_q == CNT_ZERO);
      pop_ok_s   = pop & ~is_empty_s;
      // a pop on a full FIFO frees the slot the push needs
      push_ok_s  = push & (~full_s | pop_ok_s);
      drop_s     = push & full_s & ~pop_ok_s;
   end

   // Next storage, pointers, occupancy and flags
   always_comb begin
      mem_d = mem_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = push_data;
      end else begin
         mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end

      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      empty_d = (count_d == CNT_ZERO);

      // head of the updated storage, so a push into an empty FIFO shows at once
      if (count_d != CNT_ZERO) begin
         rd_data_d = mem_d[rd_ptr_d];
      end else begin
         rd_data_d = rd_data_q;
      end

      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // FIFO state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q   <= PTR_ZERO;
         rd_ptr_q   <= PTR_ZERO;
         count_q    <= CNT_ZERO;
         rd_data_q  <= {WIDTH{1'b0}};
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/kb_event_ctrl.sv
// -----------------------------------------------------------------------------
// kb_event_ctrl
// Turns the level-type key outputs of kb_driver into discrete key events with
// typematic repeat, and queues them for the CPU.
//   CLOCK_50  : system clock
//   rst       : synchronous active-high reset
//   ascii     : key currently held (0 = none)
//   mods      : {is_error, is_special, is_capital, is_ctrl, is_shift}
//   rd_en     : pop strobe from memory_map
//   ovf_clr   : clears the sticky overflow flag
//   irq_en    : interrupt enable
//   rd_data   : queue head {repeat, 2'b00, mods, ascii}
//   empty     : queue empty
//   count     : queued entries
//   overflow  : sticky, an event was dropped on a full queue
//   kb_irq    : registered ~empty & irq_en
// Event timing: the press event is pushed the cycle after the new key is
// sampled; the first repeat follows DELAY_CYCLES later, then one every
// REPEAT_CYCLES. A different non-zero key (roll-over) restarts the delay.
// mods are captured with each event, not at press time.
// -----------------------------------------------------------------------------
module kb_event_ctrl
   import kb_event_ctrl_pkg::*;
#(
   parameter int unsigned DELAY_CYCLES  = 25000000,
   parameter int unsigned REPEAT_CYCLES = 12500000,
   parameter int          DEPTH_LOG2    = 3
) (
   input  logic                  CLOCK_50,
   input  logic                  rst,
   input  logic [7:0]            ascii,
   input  logic [4:0]            mods,
   input  logic                  rd_en,
   input  logic                  ovf_clr,
   input  logic                  irq_en,
   output logic [15:0]           rd_data,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  kb_irq
);

   // timer only has to reach the larger of the two terminal values
   localparam int unsigned TIMER_MAX = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
   localparam int          TIMER_W   = ($clog2(TIMER_MAX) < 1) ? 1 : $clog2(TIMER_MAX);

   localparam logic [TIMER_W-1:0] TIMER_ZERO  = TIMER_W'(0);
   localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(DELAY_CYCLES - 1);
   localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

   kb_state_e              state_q, state_d;
   logic [TIMER_W-1:0]     timer_q, timer_d;
   logic [7:0]             last_key_q, last_key_d;
   logic                   push_req_q, push_req_d;
   logic [KB_EVT_W-1:0]    push_data_q, push_data_d;
   logic                   kb_irq_q, kb_irq_d;

   logic                   fifo_empty_s;

   // Typematic scheduler: next state, timer and event request
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      last_key_d  = last_key_q;
      push_req_d  = 1'b0;
      push_data_d = push_data_q;

      case (state_q)
         KB_ST_IDLE: begin
            if (ascii != 8'h00) begin
               push_req_d  = 1'b1;
               push_data_d = kb_evt_pack(1'b0, mods, ascii);
               last_key_d  = ascii;
               timer_d     = TIMER_ZERO;
               state_d     = KB_ST_DELAY;
            end else begin
               state_d     = KB_ST_IDLE;
            end
         end

         KB_ST_DELAY: begin
            if (ascii == 8'h00) begin
               timer_d     = TIMER_ZERO;
               state_d     = KB_ST_IDLE;
            end else if (ascii != last_key_q) begin
               push_req_d  = 1'b1;
               push_data_d = kb_evt_pack(1'b0, mods, ascii);
               last_key_d  = ascii;
               timer_d     = TIMER_ZERO;
            end else if (timer_q == DELAY_LAST) begin
               push_req_d  = 1'b1;
               push_data_d = kb_evt_pack(1'b1, mods, ascii);
               timer_d     = TIMER_ZERO;
               state_d     = KB_ST_REPEAT;
            end else begin
               timer_d     = timer_q + TIMER_ONE;
            end
         end

         KB_ST_REPEAT: begin
            if (ascii == 8'h00) begin
               timer_d     = TIMER_ZERO;
               state_d     = KB_ST_IDLE;
            end else if (ascii != last_key_q) begin
               // a new key gets its own full initial delay
               push_req_d  = 1'b1;
               push_data_d = kb_evt_pack(1'b0, mods, ascii);
               last_key_d  = ascii;
               timer_d     = TIMER_ZERO;
               state_d     = KB_ST_DELAY;
            end else if (timer_q == REPEAT_LAST) begin
               push_req_d  = 1'b1;
               push_data_d = kb_evt_pack(1'b1, mods, ascii);
               timer_d     = TIMER_ZERO;
            end else begin
               timer_d     = timer_q + TIMER_ONE;
            end
         end

         default: begin
            timer_d = TIMER_ZERO;
            state_d = KB_ST_IDLE;
         end
      endcase
   end

   // Interrupt request follows the registered empty flag by one cycle
   always_comb begin
      kb_irq_d = ~fifo_empty_s & irq_en;
   end

   // Scheduler and interrupt registers
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q     <= KB_ST_IDLE;
         timer_q     <= TIMER_ZERO;
         last_key_q  <= 8'h00;
         push_req_q  <= 1'b0;
         push_data_q <= 16'h0000;
         kb_irq_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         last_key_q  <= last_key_d;
         push_req_q  <= push_req_d;
         push_data_q <= push_data_d;
         kb_irq_q    <= kb_irq_d;
      end
   end

   kb_event_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (KB_EVT_W)
   ) u_fifo (
      .clk        (CLOCK_50),
      .rst        (rst),
      .push       (push_req_q),
      .push_data  (push_data_q),
      .pop        (rd_en),
      .ovf_clr    (ovf_clr),
      .rd_data    (rd_data),
      .empty      (fifo_empty_s),
      .count      (count),
      .overflow   (overflow)
   );

   assign empty  = fifo_empty_s;
   assign kb_irq = kb_irq_q;

endmodule

// File: tb/tb_kb_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kb_event_ctrl
// Directed bench for kb_event_ctrl with DELAY_CYCLES=10, REPEAT_CYCLES=4,
// DEPTH_LOG2=2. A reference model derives event times from the age of the
// current key press and keeps the queue as a plain SV queue; every cycle the
// DUT outputs are compared with it. Hand-computed literals pin the model.
// -----------------------------------------------------------------------------
module tb_kb_event_ctrl;

   localparam int D     = 10;
   localparam int R     = 4;
   localparam int DL2   = 2;
   localparam int DEPTH = 1 << DL2;

   logic          clk;
   logic          rst;
   logic [7:0]    ascii;
   logic [4:0]    mods;
   logic          rd_en;
   logic          ovf_clr;
   logic          irq_en;
   logic [15:0]   rd_data;
   logic          empty;
   logic [DL2:0]  count;
   logic          overflow;
   logic          kb_irq;

   int n_checks;
   int n_pass;

   kb_event_ctrl #(
      .DELAY_CYCLES  (D),
      .REPEAT_CYCLES (R),
      .DEPTH_LOG2    (DL2)
   ) dut (
      .CLOCK_50 (clk),
      .rst      (rst),
      .ascii    (ascii),
      .mods     (mods),
      .rd_en    (rd_en),
      .ovf_clr  (ovf_clr),
      .irq_en   (irq_en),
      .rd_data  (rd_data),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .kb_irq   (kb_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] q[$];
   logic [7:0]  held;
   int          cyc;
   int          press_cyc;
   logic        pend_v;
   logic [15:0] pend_d;
   logic        m_ovf;
   logic [15:0] m_rdd;
   logic        m_irq;
   logic        m_valid;

   initial begin
      m_valid = 1'b0;
      cyc     = 0;
   end

   always @(posedge clk) begin
      logic pop_ok;
      logic full_m;
      logic drop;
      int   age;
      cyc = cyc + 1;
      if (rst) begin
         q.delete();
         held    = 8'h00;
         pend_v  = 1'b0;
         pend_d  = 16'h0000;
         m_ovf   = 1'b0;
         m_rdd   = 16'h0000;
         m_irq   = 1'b0;
         m_valid = 1'b1;
      end else begin
         m_irq  = (q.size() != 0) && irq_en;
         pop_ok = rd_en && (q.size() != 0);
         full_m = (q.size() == DEPTH);
         drop   = pend_v && full_m && !pop_ok;
         if (pop_ok) void'(q.pop_front());
         if (pend_v && !drop) q.push_back(pend_d);
         if (drop) m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         if (q.size() != 0) m_rdd = q[0];

         // event due for this sample, pushed on the following edge
         pend_v = 1'b0;
         if (ascii == 8'h00) begin
            held = 8'h00;
         end else if (ascii != held) begin
            held      = ascii;
            press_cyc = cyc;
            pend_v    = 1'b1;
            pend_d    = {1'b0, 2'b00, mods, ascii};
         end else begin
            age = cyc - press_cyc;
            if (age == D || (age > D && ((age - D) % R) == 0)) begin
               pend_v = 1'b1;
               pend_d = {1'b1, 2'b00, mods, ascii};
            end
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_valid) begin
         check("m_count",    32'(count),    32'(q.size()));
         check("m_empty",    32'(empty),    32'(q.size() == 0));
         check("m_rd_data",  32'(rd_data),  32'(m_rdd));
         check("m_overflow", 32'(overflow), 32'(m_ovf));
         check("m_kb_irq",   32'(kb_irq),   32'(m_irq));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_expect(input string name, input logic [15:0] exp);
      check(name, 32'(rd_data), 32'(exp));
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      ascii    = 8'h00;
      mods     = 5'b00000;
      rd_en    = 1'b0;
      ovf_clr  = 1'b0;
      irq_en   = 1'b0;
      tick(3);
      check("rst_count",    32'(count),    32'h0);
      check("rst_empty",    32'(empty),    32'h1);
      check("rst_rd_data",  32'(rd_data),  32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      check("rst_kb_irq",   32'(kb_irq),   32'h0);
      rst = 1'b0;
      tick(2);

      // tap
      ascii = 8'h61;
      tick(5);
      ascii = 8'h00;
      tick(3);
      check("tap_count", 32'(count),   32'h1);
      check("tap_head",  32'(rd_data), 32'h0061);
      pop_expect("tap_pop", 16'h0061);
      check("tap_empty", 32'(empty),   32'h1);
      check("tap_hold",  32'(rd_data), 32'h0061);

      // hold with shift
      ascii = 8'h41;
      mods  = 5'b00001;
      tick(22);
      ascii = 8'h00;
      mods  = 5'b00000;
      tick(3);
      check("hold_count", 32'(count),    32'h4);
      check("hold_ovf",   32'(overflow), 32'h0);
      pop_expect("hold_e0", 16'h0141);
      pop_expect("hold_e1", 16'h8141);
      pop_expect("hold_e2", 16'h8141);
      pop_expect("hold_e3", 16'h8141);
      check("hold_empty", 32'(empty), 32'h1);

      // roll-over
      ascii = 8'h61;
      tick(6);
      ascii = 8'h62;
      tick(12);
      ascii = 8'h00;
      tick(3);
      check("roll_count", 32'(count), 32'h3);
      pop_expect("roll_e0", 16'h0061);
      pop_expect("roll_e1", 16'h0062);
      pop_expect("roll_e2", 16'h8062);
      check("roll_empty", 32'(empty), 32'h1);

      // overflow: five events into four slots
      ascii = 8'h41;
      tick(23);
      ascii = 8'h00;
      tick(3);
      check("ovf_count", 32'(count),    32'h4);
      check("ovf_set",   32'(overflow), 32'h1);
      check("ovf_head",  32'(rd_data),  32'h0041);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      check("ovf_clr",      32'(overflow), 32'h0);
      check("ovf_head2",    32'(rd_data),  32'h0041);
      check("ovf_count2",   32'(count),    32'h4);

      // push and pop together while full
      ascii = 8'h63;
      tick(1);
      ascii = 8'h00;
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      check("full_pp_count", 32'(count),    32'h4);
      check("full_pp_ovf",   32'(overflow), 32'h0);
      pop_expect("full_pp_e0", 16'h8041);
      pop_expect("full_pp_e1", 16'h8041);
      pop_expect("full_pp_e2", 16'h8041);
      pop_expect("full_pp_e3", 16'h0063);
      check("drain_empty", 32'(empty), 32'h1);

      // pop on empty is ignored
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      check("pop_empty_count", 32'(count), 32'h0);

      // irq, push into empty with a simultaneous pop, reset mid-delay
      irq_en = 1'b1;
      ascii  = 8'h64;
      tick(1);
      rd_en  = 1'b1;
      tick(1);
      rd_en  = 1'b0;
      tick(1);
      check("pe_count", 32'(count),  32'h1);
      check("irq_on",   32'(kb_irq), 32'h1);
      rst = 1'b1;
      tick(1);
      check("rst_mid_empty", 32'(empty),  32'h1);
      check("rst_mid_count", 32'(count),  32'h0);
      check("rst_mid_irq",   32'(kb_irq), 32'h0);
      rst = 1'b0;
      tick(2);
      check("post_rst_count", 32'(count),   32'h1);
      check("post_rst_head",  32'(rd_data), 32'h0064);
      tick(12);
      check("post_rst_rep_count", 32'(count), 32'h2);
      irq_en = 1'b0;
      tick(1);
      check("irq_off", 32'(kb_irq), 32'h0);
      ascii = 8'h00;
      tick(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
